// File: rtl/i2s_rx_framer.sv
// Purpose: Philips I2S receive framer; assembles 16/32-bit L/R words and queues {ch, word} in a dual-clock FIFO.
// Latency: word pushed on its LSB wclk edge (N wclk after the WS edge); empty clears 2-3 rclk later; pop registers dout in 1 rclk.
// Backpressure: none toward the serial link; a word completed while full is dropped and flagged by the sticky overrun.
//
// Optional feature macro: I2S_RX_FRAME_ERR_EN adds frame_err, a sticky short-frame flag synchronized to rclk.
// Ports (wclk side): wclk, rst_, en, frame16, sd, ws, full.
// Ports (rclk side): rclk, rd, dout, dout_ch, empty, overrun [, frame_err].
// rst_ is asynchronous, active-low and resets both clock domains.
module i2s_rx_framer #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic             wclk,
    input  logic             rst_,
    input  logic             rclk,
    input  logic             en,
    input  logic             frame16,
    input  logic             sd,
    input  logic             ws,
    input  logic             rd,
    output logic [WIDTH-1:0] dout,
    output logic             dout_ch,
    output logic             empty,
    output logic             full,
    output logic             overrun
`ifdef I2S_RX_FRAME_ERR_EN
    ,
    output logic             frame_err
`endif
);
    localparam int CW    = $clog2(WIDTH);
    localparam int PW    = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    // Full when the Gray pointers differ exactly in their two top bits.
    localparam logic [PW-1:0] FULL_XOR = PW'(3) << (PW - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        WAIT = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Serial sampling and framing (wclk domain)
    // ------------------------------------------------------------------
    state_t           state_q;
    state_t           state_d;
    logic             ws_q;
    logic [CW-1:0]    cnt_q;
    logic             ch_q;
    logic [WIDTH-2:0] shreg_q;

    logic             ws_edge;
    logic             cnt_zero;
    logic [CW-1:0]    cnt_load;
    logic             start;
    logic             shift;
    logic             push_req;
    logic [WIDTH:0]   push_dat;

    assign ws_edge  = (ws != ws_q);
    assign cnt_zero = (cnt_q == '0);
    assign cnt_load = frame16 ? CW'(15) : CW'(WIDTH - 1);

    // The LSB is the bit sampled on the push edge itself, so it goes straight
    // from sd into the entry. The shift register is cleared at word start,
    // which zero-extends 16-bit words for free.
    assign push_dat = {ch_q, shreg_q, sd};

    // ws_q tracks ws regardless of en so the first edge after enable is real.
    always_ff @(posedge wclk or negedge rst_) begin
        if (!rst_) begin
            ws_q <= 1'b0;
        end else begin
            ws_q <= ws;
        end
    end

    // FSM: state register
    always_ff @(posedge wclk or negedge rst_) begin
        if (!rst_) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, WAIT: begin
                    if (ws_edge) begin
                        state_d = RECV;
                    end
                end
                RECV: begin
                    // A WS edge always restarts RECV; a complete word with no
                    // edge parks in WAIT so padding bits are ignored.
                    if (!ws_edge && cnt_zero) begin
                        state_d = WAIT;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        start    = 1'b0;
        shift    = 1'b0;
        push_req = 1'b0;
        if (en) begin
            case (state_q)
                IDLE, WAIT: begin
                    // The bit on the WS edge belongs to the previous slot.
                    start = ws_edge;
                end
                RECV: begin
                    // cnt==0 means this edge carries the LSB, whether or not
                    // WS toggles on it. A WS edge with cnt>0 is a short frame:
                    // restarting without a push discards the partial word.
                    push_req = cnt_zero;
                    start    = ws_edge;
                    shift    = !ws_edge && !cnt_zero;
                end
                default: ;
            endcase
        end
    end

    // Word datapath
    always_ff @(posedge wclk or negedge rst_) begin
        if (!rst_) begin
            cnt_q   <= '0;
            ch_q    <= 1'b0;
            shreg_q <= '0;
        end else if (!en) begin
            cnt_q   <= '0;
            shreg_q <= '0;
        end else if (start) begin
            cnt_q   <= cnt_load;
            ch_q    <= ws;
            shreg_q <= '0;
        end else if (shift) begin
            cnt_q   <= cnt_q - 1'b1;
            shreg_q <= {shreg_q[WIDTH-3:0], sd};
        end
    end

    // ------------------------------------------------------------------
    // FIFO write side (wclk domain)
    // ------------------------------------------------------------------
    logic [WIDTH:0]  mem [DEPTH];
    logic [PW-1:0]   wbin_q;
    logic [PW-1:0]   wgray_q;
    logic [PW-1:0]   wbin_d;
    logic [PW-1:0]   wgray_d;
    logic [PW-1:0]   rq1_q;
    logic [PW-1:0]   rq2_q;
    logic            do_push;
    logic            ovr_w_q;

    assign do_push = push_req && !full;
    assign wbin_d  = wbin_q + PW'(do_push);
    assign wgray_d = wbin_d ^ (wbin_d >> 1);

    // Compared against a stale read pointer, so full can only linger, never
    // clear early.
    assign full = ((wgray_q ^ rq2_q) == FULL_XOR);

    always_ff @(posedge wclk or negedge rst_) begin
        if (!rst_) begin
            wbin_q  <= '0;
            wgray_q <= '0;
            rq1_q   <= '0;
            rq2_q   <= '0;
        end else begin
            wbin_q  <= wbin_d;
            wgray_q <= wgray_d;
            rq1_q   <= rgray_q;
            rq2_q   <= rq1_q;
        end
    end

    // Storage has no reset; an entry is only read once the pointers say it
    // was written.
    always_ff @(posedge wclk) begin
        if (do_push) begin
            mem[wbin_q[DEPTH_LOG2-1:0]] <= push_dat;
        end
    end

    // Sticky drop flag; disabling the receiver is the only way to clear it.
    always_ff @(posedge wclk or negedge rst_) begin
        if (!rst_) begin
            ovr_w_q <= 1'b0;
        end else if (!en) begin
            ovr_w_q <= 1'b0;
        end else if (push_req && full) begin
            ovr_w_q <= 1'b1;
        end
    end

`ifdef I2S_RX_FRAME_ERR_EN
    logic short_err;
    logic ferr_w_q;
    logic ferr_s1_q;

    assign short_err = en && (state_q == RECV) && ws_edge && !cnt_zero;

    always_ff @(posedge wclk or negedge rst_) begin
        if (!rst_) begin
            ferr_w_q <= 1'b0;
        end else if (!en) begin
            ferr_w_q <= 1'b0;
        end else if (short_err) begin
            ferr_w_q <= 1'b1;
        end
    end

    always_ff @(posedge rclk or negedge rst_) begin
        if (!rst_) begin
            ferr_s1_q <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            ferr_s1_q <= ferr_w_q;
            frame_err <= ferr_s1_q;
        end
    end
`endif

    // ------------------------------------------------------------------
    // FIFO read side (rclk domain)
    // ------------------------------------------------------------------
    logic [PW-1:0] rbin_q;
    logic [PW-1:0] rgray_q;
    logic [PW-1:0] rbin_d;
    logic [PW-1:0] rgray_d;
    logic [PW-1:0] wq1_q;
    logic [PW-1:0] wq2_q;
    logic          do_pop;
    logic          ovr_s1_q;

    // Compared against a stale write pointer, so empty can only linger.
    assign empty   = (rgray_q == wq2_q);
    assign do_pop  = rd && !empty;
    assign rbin_d  = rbin_q + PW'(do_pop);
    assign rgray_d = rbin_d ^ (rbin_d >> 1);

    always_ff @(posedge rclk or negedge rst_) begin
        if (!rst_) begin
            rbin_q   <= '0;
            rgray_q  <= '0;
            wq1_q    <= '0;
            wq2_q    <= '0;
            dout     <= '0;
            dout_ch  <= 1'b0;
            ovr_s1_q <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            rbin_q   <= rbin_d;
            rgray_q  <= rgray_d;
            wq1_q    <= wgray_q;
            wq2_q    <= wq1_q;
            ovr_s1_q <= ovr_w_q;
            overrun  <= ovr_s1_q;
            if (do_pop) begin
                {dout_ch, dout} <= mem[rbin_q[DEPTH_LOG2-1:0]];
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx_framer.sv
`timescale 1ns/1ps
module tb_i2s_rx_framer;
    localparam int WIDTH = 32;
    localparam int DL2   = 2;
    localparam int DEPTH = 4;

    logic             wclk = 1'b0;
    logic             rclk = 1'b0;
    logic             rst_;
    logic             en;
    logic             frame16;
    logic             sd;
    logic             ws;
    logic             rd;
    logic [WIDTH-1:0] dout;
    logic             dout_ch;
    logic             empty;
    logic             full;
    logic             overrun;
`ifdef I2S_RX_FRAME_ERR_EN
    logic             frame_err;
`endif

    always #5 wclk = ~wclk;
    always #7 rclk = ~rclk;

    i2s_rx_framer #(.WIDTH(WIDTH), .DEPTH_LOG2(DL2)) dut (
        .wclk    (wclk),
        .rst_    (rst_),
        .rclk    (rclk),
        .en      (en),
        .frame16 (frame16),
        .sd      (sd),
        .ws      (ws),
        .rd      (rd),
        .dout    (dout),
        .dout_ch (dout_ch),
        .empty   (empty),
        .full    (full),
        .overrun (overrun)
`ifdef I2S_RX_FRAME_ERR_EN
        ,
        .frame_err (frame_err)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Slot list: each slot is a stretch of constant ws of a given length,
    // carrying one word MSB-first starting one bit after its ws edge.
    int               s_ws[$];
    int               s_len[$];
    logic [WIDTH-1:0] s_dat[$];

    // Reference results for the current stream.
    logic [WIDTH:0]   exp_q[$];
    logic             exp_ovr;
    logic             exp_ferr;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wcyc(input int n);
        repeat (n) @(negedge wclk);
    endtask

    task automatic rcyc(input int n);
        repeat (n) @(negedge rclk);
    endtask

    task automatic clear_slots();
        s_ws.delete();
        s_len.delete();
        s_dat.delete();
    endtask

    task automatic add_slot(input int w, input int l, input logic [WIDTH-1:0] d);
        s_ws.push_back(w);
        s_len.push_back(l);
        s_dat.push_back(d);
    endtask

    // Builds the bit stream from the slot list, derives the expected FIFO
    // contents, then drives it (stopping before bit index cut when cut >= 0).
    task automatic drive_stream(input int cut);
        int               n;
        int               pos;
        int               attempts;
        logic             ws_b[$];
        logic             sd_b[$];
        logic [WIDTH-1:0] mask;
        n    = frame16 ? 16 : 32;
        mask = frame16 ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        for (int k = 0; k < s_ws.size(); k++) begin
            for (int i = 0; i < s_len[k]; i++) begin
                ws_b.push_back(s_ws[k][0]);
                sd_b.push_back(1'($urandom_range(0, 1)));
            end
        end
        pos = 0;
        for (int k = 0; k < s_ws.size(); k++) begin
            if (k > 0) begin
                for (int i = 1; i <= n && i <= s_len[k]; i++) begin
                    sd_b[pos + i] = s_dat[k][n - i];
                end
            end
            pos += s_len[k];
        end
        // Slot 0 precedes the first WS edge after enable and is never kept.
        // Later slots are kept if they are at least N bits long; shorter ones
        // are frame errors. Only DEPTH words fit without pops.
        attempts = 0;
        exp_ferr = 1'b0;
        exp_q.delete();
        for (int k = 1; k < s_ws.size(); k++) begin
            if (s_len[k] >= n) begin
                attempts++;
                if (exp_q.size() < DEPTH) begin
                    exp_q.push_back({s_ws[k][0], s_dat[k] & mask});
                end
            end else begin
                exp_ferr = 1'b1;
            end
        end
        exp_ovr = (attempts > DEPTH);

        en = 1'b0;
        ws = ws_b[0];
        sd = 1'b0;
        wcyc(3);
        for (int i = 0; i < ws_b.size(); i++) begin
            if (cut >= 0 && i == cut) break;
            ws = ws_b[i];
            sd = sd_b[i];
            en = 1'b1;
            @(negedge wclk);
        end
    endtask

    task automatic pop_one(input string tag, input logic [WIDTH:0] e);
        int t;
        t = 0;
        while (empty && t < 50) begin
            @(negedge rclk);
            t++;
        end
        check({tag, " avail"}, empty, 1'b0);
        rd = 1'b1;
        @(negedge rclk);
        rd = 1'b0;
        check({tag, " dat"}, dout, e[WIDTH-1:0]);
        check({tag, " ch"}, dout_ch, e[WIDTH]);
    endtask

    task automatic check_after(input string tag);
        wcyc(2);
        rcyc(8);
        check({tag, " full"}, full, (exp_q.size() == DEPTH));
        check({tag, " overrun"}, overrun, exp_ovr);
`ifdef I2S_RX_FRAME_ERR_EN
        check({tag, " frame_err"}, frame_err, exp_ferr);
`endif
        while (exp_q.size() > 0) begin
            pop_one(tag, exp_q.pop_front());
        end
        rcyc(3);
        check({tag, " empty"}, empty, 1'b1);
        wcyc(4);
        check({tag, " full clr"}, full, 1'b0);
        en = 1'b0;
        wcyc(3);
        rcyc(4);
        check({tag, " ovr clr"}, overrun, 1'b0);
`ifdef I2S_RX_FRAME_ERR_EN
        check({tag, " ferr clr"}, frame_err, 1'b0);
`endif
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] w;
        int               n;
        int               nsl;
        int               kind;
        int               len;

        rst_ = 1'b0; en = 1'b0; frame16 = 1'b0; sd = 1'b0; ws = 1'b0; rd = 1'b0;
        wcyc(3);
        check("rst dout", dout, 0);
        check("rst dout_ch", dout_ch, 1'b0);
        check("rst empty", empty, 1'b1);
        check("rst full", full, 1'b0);
        check("rst overrun", overrun, 1'b0);
`ifdef I2S_RX_FRAME_ERR_EN
        check("rst frame_err", frame_err, 1'b0);
`endif
        rst_ = 1'b1;
        wcyc(2);

        // rd held high on an empty FIFO, then one word arrives.
        rd = 1'b1;
        rcyc(10);
        check("rdhold dout idle", dout, 0);
        check("rdhold empty idle", empty, 1'b1);
        clear_slots();
        w = $urandom;
        add_slot(1, 5, '0);
        add_slot(0, 33, w);
        drive_stream(-1);
        rcyc(8);
        check("rdhold dout", dout, w);
        check("rdhold ch", dout_ch, 1'b0);
        check("rdhold empty", empty, 1'b1);
        rcyc(5);
        check("rdhold dout stable", dout, w);
        rd = 1'b0;
        en = 1'b0;
        wcyc(3);

        // 32-bit L/R stream with a leading partial frame.
        frame16 = 1'b0;
        clear_slots();
        add_slot(1, 20, '0);
        add_slot(0, 32, 32'hDEAD_BEEF);
        add_slot(1, 40, 32'h1234_5678);
        drive_stream(-1);
        check_after("t32");

        // 16-bit words in 32-bit slots (padding goes through WAIT).
        frame16 = 1'b1;
        clear_slots();
        add_slot(1, 20, '0);
        add_slot(0, 32, 32'h0000_A5C3);
        add_slot(1, 33, 32'h0000_0F0F);
        drive_stream(-1);
        check_after("t16");

        // Six words with no pops: four kept, overrun set.
        frame16 = 1'b0;
        clear_slots();
        add_slot(1, 7, '0);
        for (int i = 1; i <= 6; i++) begin
            add_slot((i % 2 == 0) ? 1 : 0, (i == 6) ? 40 : 32, $urandom);
        end
        drive_stream(-1);
        check_after("tovf");

        // Short 10-bit frame followed by full frames.
        frame16 = 1'b0;
        clear_slots();
        add_slot(1, 5, '0);
        add_slot(0, 10, $urandom);
        add_slot(1, 32, 32'hCAFE_F00D);
        add_slot(0, 36, 32'h8000_0001);
        drive_stream(-1);
        check_after("tshort");

        // Reset mid-word with two words queued.
        frame16 = 1'b0;
        clear_slots();
        add_slot(1, 5, '0);
        add_slot(0, 32, $urandom);
        add_slot(1, 32, $urandom);
        add_slot(0, 40, $urandom);
        drive_stream(79);
        check("trst queued", empty, 1'b0);
        #2;
        rst_ = 1'b0;
        #1;
        check("trst dout", dout, 0);
        check("trst ch", dout_ch, 1'b0);
        check("trst empty", empty, 1'b1);
        check("trst full", full, 1'b0);
        en = 1'b0;
        wcyc(1);
        rst_ = 1'b1;
        wcyc(40);
        rcyc(4);
        check("trst no stale", empty, 1'b1);
        check("trst dout after", dout, 0);

        // Randomized slot lengths: exact, padded and short frames.
        for (int r = 0; r < 6; r++) begin
            frame16 = 1'($urandom_range(0, 1));
            n = frame16 ? 16 : 32;
            nsl = $urandom_range(3, 5);
            clear_slots();
            add_slot(1, $urandom_range(2, 40), '0);
            for (int k = 1; k < nsl; k++) begin
                kind = $urandom_range(0, 2);
                if (k == nsl - 1 || kind == 1) len = n + $urandom_range(1, 8);
                else if (kind == 0)            len = n;
                else                           len = $urandom_range(2, n - 1);
                add_slot((k % 2 == 0) ? 1 : 0, len, $urandom);
            end
            drive_stream(-1);
            check_after($sformatf("rnd%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
